// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue block: datapath sizes, opcode map and FSM encoding.
package alu_issue_pkg;

  localparam int DATA_W = 8;
  localparam int REG_N  = 8;
  localparam int REG_W  = $clog2(REG_N);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOT  = 4'b0101,
    OP_SHL  = 4'b0110,
    OP_SHR  = 4'b0111,
    OP_NAND = 4'b1000,
    OP_NOR  = 4'b1001,
    OP_INC  = 4'b1010,
    OP_DEC  = 4'b1011,
    OP_EQ   = 4'b1100,
    OP_LDI  = 4'b1101,
    OP_NOP1 = 4'b1110,
    OP_NOP2 = 4'b1111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  // Everything except the two no-ops retires into the register file.
  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_EQ) || (op == OP_LDI);
  endfunction

  function automatic logic op_has_carry(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Instruction, external-ALU and retirement signals of the issue block.
interface alu_issue_if import alu_issue_pkg::*; ();

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [REG_W-1:0]  in_rd;
  logic [REG_W-1:0]  in_rs;
  logic [REG_W-1:0]  in_rt;
  logic [DATA_W-1:0] in_imm;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_x;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_carry;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm, alu_out, alu_carry,
    output in_ready, alu_ctrl, alu_x, alu_y, out_valid, out_data, out_carry
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs, in_rt, in_imm, alu_out, alu_carry,
    input  in_ready, alu_ctrl, alu_x, alu_y, out_valid, out_data, out_carry
  );

endinterface

// File: rtl/alu_regfile.sv
// General register file: two asynchronous read ports, one synchronous write port.
module alu_regfile import alu_issue_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [REG_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_issue.sv
// Single-issue sequencer in front of an external combinational ALU.
// state | meaning
// IDLE  | ready for an instruction; operands latched on accept
// EXEC  | ALU settles on held operands; result captured at closing edge
// WB    | result presented for one cycle; register write at exit edge
module alu_issue #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  import alu_issue_pkg::*;

  localparam int RW = $clog2(REG_N);

  state_e            state, state_nx;
  logic              accept;
  logic              we;
  logic [3:0]        op_q;
  logic [RW-1:0]     rd_q;
  logic [DATA_W-1:0] imm_q, x_q, y_q, data_q;
  logic              carry_q;
  logic [DATA_W-1:0] rdata_a, rdata_b, res_d;
  logic              carry_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    accept       = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (bus.in_valid) state_nx = ST_EXEC;
      end
      ST_EXEC: state_nx = ST_WB;
      ST_WB: begin
        bus.out_valid = 1'b1;
        state_nx      = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Result selection: immediate for LDI, zero for the no-ops, ALU otherwise.
  always_comb begin
    res_d   = bus.alu_out;
    carry_d = 1'b0;
    if (op_q == OP_LDI)       res_d = imm_q;
    else if (op_q >= OP_NOP1) res_d = '0;
    if (op_has_carry(op_q))   carry_d = bus.alu_carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_LDI;
      rd_q    <= '0;
      imm_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.in_op;
        rd_q  <= bus.in_rd;
        imm_q <= bus.in_imm;
        x_q   <= rdata_a;
        y_q   <= rdata_b;
      end
      if (state == ST_EXEC) begin
        data_q  <= res_d;
        carry_q <= carry_d;
      end
    end
  end

  assign we            = (state == ST_WB) && op_writes(op_q);
  assign bus.alu_ctrl  = op_q;
  assign bus.alu_x     = x_q;
  assign bus.alu_y     = y_q;
  assign bus.out_data  = data_q;
  assign bus.out_carry = carry_q;

  alu_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (rd_q),
    .wdata   (data_q),
    .raddr_a (bus.in_rs),
    .raddr_b (bus.in_rt),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: external ALU model, instruction-level reference model, directed and random stimulus.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_issue_if ifc();

  alu_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // External ALU; logic ops raise junk carries so carry masking is exercised.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] r;
    case (op)
      4'd0:    r = {1'b0, x} + {1'b0, y};
      4'd1:    r = {x < y, x - y};
      4'd2:    r = {1'b1, x & y};
      4'd3:    r = {1'b0, x | y};
      4'd4:    r = {1'b1, x ^ y};
      4'd5:    r = {x[0], ~x};
      4'd6:    r = {x[7], x << 1};
      4'd7:    r = {x[0], x >> 1};
      4'd8:    r = {1'b1, ~(x & y)};
      4'd9:    r = {1'b1, ~(x | y)};
      4'd10:   r = {1'b0, x} + 9'd1;
      4'd11:   r = {x == 8'd0, x - 8'd1};
      4'd12:   r = {1'b1, 7'd0, x == y};
      default: r = {1'b1, x ^ y ^ 8'hA5};
    endcase
    return r;
  endfunction

  assign {ifc.alu_carry, ifc.alu_out} = alu_f(ifc.alu_ctrl, ifc.alu_x, ifc.alu_y);

  logic [7:0] m_rf [8];
  int         busy;
  logic [3:0] h_op;
  logic [7:0] h_x, h_y;
  logic [2:0] p_rd;
  logic [7:0] p_data, last_d;
  logic       p_carry, p_we, last_c;
  int         cyc = 0;
  int         acc_cnt = 0;
  int         last_acc = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    busy   = 0;
    h_op   = 4'hD;
    h_x    = 8'h00;
    h_y    = 8'h00;
    last_d = 8'h00;
    last_c = 1'b0;
  endtask

  // Reference model advances on rising edges; DUT is compared on falling edges.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (!rst_n) begin
        m_reset();
      end else if (busy == 1) begin
        if (p_we) m_rf[p_rd] = p_data;
        last_d = p_data;
        last_c = p_carry;
        busy   = 0;
      end else if (busy == 2) begin
        busy = 1;
      end else if (ifc.in_valid) begin
        logic [8:0] r;
        h_op = ifc.in_op;
        h_x  = m_rf[ifc.in_rs];
        h_y  = m_rf[ifc.in_rt];
        p_rd = ifc.in_rd;
        r    = alu_f(h_op, h_x, h_y);
        if (h_op == OP_LDI) begin
          p_data = ifc.in_imm; p_carry = 1'b0; p_we = 1'b1;
        end else if (h_op >= OP_NOP1) begin
          p_data = 8'h00; p_carry = 1'b0; p_we = 1'b0;
        end else begin
          p_data  = r[7:0];
          p_carry = (h_op == OP_ADD || h_op == OP_SUB) ? r[8] : 1'b0;
          p_we    = 1'b1;
        end
        busy     = 2;
        acc_cnt  = acc_cnt + 1;
        last_acc = cyc;
      end
      cyc = cyc + 1;
    end else begin
      if (!rst_n) begin
        m_reset();
        chk("rst_out_valid", ifc.out_valid, 0);
        chk("rst_out_data", ifc.out_data, 0);
        chk("rst_out_carry", ifc.out_carry, 0);
        chk("rst_alu_ctrl", ifc.alu_ctrl, 4'hD);
        chk("rst_alu_x", ifc.alu_x, 0);
        chk("rst_alu_y", ifc.alu_y, 0);
      end else begin
        chk("in_ready", ifc.in_ready, busy == 0);
        chk("out_valid", ifc.out_valid, busy == 1);
        chk("out_data", ifc.out_data, (busy == 1) ? p_data : last_d);
        chk("out_carry", ifc.out_carry, (busy == 1) ? p_carry : last_c);
        chk("alu_ctrl", ifc.alu_ctrl, h_op);
        chk("alu_x", ifc.alu_x, h_x);
        chk("alu_y", ifc.alu_y, h_y);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic [7:0] imm, input bit keep);
    int n0;
    bit ok;
    ifc.in_valid = 1'b1;
    ifc.in_op    = op;
    ifc.in_rd    = rd;
    ifc.in_rs    = rs;
    ifc.in_rt    = rt;
    ifc.in_imm   = imm;
    n0 = acc_cnt;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != n0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (!keep) ifc.in_valid = 1'b0;
  endtask

  task automatic retire();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                     input logic [2:0] rt, input logic [7:0] imm);
    issue(op, rd, rs, rt, imm, 1'b0);
    retire();
  endtask

  initial begin
    int a0, rel;
    ifc.in_valid = 1'b0;
    ifc.in_op    = 4'h0;
    ifc.in_rd    = 3'd0;
    ifc.in_rs    = 3'd0;
    ifc.in_rt    = 3'd0;
    ifc.in_imm   = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rel = cyc;
    chk("ready_after_rst", ifc.in_ready, 1);

    issue(OP_LDI, 3'd1, 3'd0, 3'd0, 8'h1F, 1'b0);
    chk("first_accept_edge", last_acc, rel);
    retire();
    run(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h11);
    run(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00);
    chk("add_data", ifc.out_data, 8'h30);
    chk("add_carry", ifc.out_carry, 0);
    chk("model_r3", m_rf[3], 8'h30);
    run(OP_SUB, 3'd4, 3'd1, 3'd2, 8'h00);
    chk("sub_data", ifc.out_data, 8'h0E);
    chk("sub_carry", ifc.out_carry, 0);
    run(OP_XOR, 3'd5, 3'd1, 3'd2, 8'h00);
    chk("xor_data", ifc.out_data, 8'h0E);
    chk("xor_carry", ifc.out_carry, 0);
    run(OP_LDI, 3'd6, 3'd0, 3'd0, 8'hFF);
    run(OP_LDI, 3'd7, 3'd0, 3'd0, 8'h01);
    run(OP_ADD, 3'd0, 3'd6, 3'd7, 8'h00);
    chk("addc_data", ifc.out_data, 8'h00);
    chk("addc_carry", ifc.out_carry, 1);
    run(OP_AND, 3'd5, 3'd1, 3'd2, 8'h00);
    chk("and_data", ifc.out_data, 8'h11);
    chk("and_carry", ifc.out_carry, 0);
    run(OP_NOP1, 3'd3, 3'd1, 3'd2, 8'h55);
    chk("nop_data", ifc.out_data, 8'h00);
    chk("nop_carry", ifc.out_carry, 0);
    run(OP_LDI, 3'd0, 3'd0, 3'd0, 8'h00);
    run(OP_ADD, 3'd4, 3'd3, 3'd0, 8'h00);
    chk("nop_no_write_r3", ifc.out_data, 8'h30);
    run(OP_ADD, 3'd1, 3'd1, 3'd1, 8'h00);
    chk("alias_pre_write", ifc.out_data, 8'h3E);

    // Back-to-back with in_valid held high: one accept every three cycles.
    issue(OP_ADD, 3'd2, 3'd1, 3'd2, 8'h00, 1'b1);
    a0 = last_acc;
    issue(OP_SUB, 3'd6, 3'd2, 3'd1, 8'h00, 1'b1);
    chk("b2b_gap1", last_acc - a0, 3);
    a0 = last_acc;
    issue(OP_INC, 3'd7, 3'd7, 3'd0, 8'h00, 1'b1);
    chk("b2b_gap2", last_acc - a0, 3);
    a0 = last_acc;
    issue(OP_LDI, 3'd0, 3'd0, 3'd0, 8'hAA, 1'b0);
    chk("b2b_gap3", last_acc - a0, 3);
    retire();
    chk("b2b_last_data", ifc.out_data, 8'hAA);
    chk("model_r2", m_rf[2], 8'h4F);
    chk("model_r6", m_rf[6], 8'h11);

    // Reset during EXEC aborts the instruction.
    issue(OP_ADD, 3'd2, 3'd1, 3'd1, 8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_ready", ifc.in_ready, 1);
    chk("abort_out_data", ifc.out_data, 0);
    run(OP_ADD, 3'd4, 3'd2, 3'd2, 8'h00);
    chk("abort_r2_zero", ifc.out_data, 8'h00);

    // Random traffic, including in_valid while busy and rare resets.
    for (int i = 0; i < 600; i++) begin
      ifc.in_valid = ($urandom_range(0, 3) != 0);
      ifc.in_op    = 4'($urandom_range(0, 15));
      ifc.in_rd    = 3'($urandom_range(0, 7));
      ifc.in_rs    = 3'($urandom_range(0, 7));
      ifc.in_rt    = 3'($urandom_range(0, 7));
      ifc.in_imm   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
    end
    ifc.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
